// File: rtl/win_avg.sv
// win_avg -- sliding-window averager over the last 2^LOG2_N signed samples.
//
// One sample is accepted per rising edge with en=1. The last N = 2^LOG2_N
// samples live in a circular buffer; a running window sum is kept and a
// registered average (sum / N, done as a shift) is produced alongside it.
//
// Ports:
//   clk    in   1        clock, rising edge
//   rst    in   1        synchronous active-high reset
//   clr    in   1        synchronous window clear (same effect as rst)
//   en     in   1        sample strobe
//   x      in   DATA_W   signed sample
//   sum    out  ACC_W    signed sum of samples currently in the window
//   avg    out  DATA_W   signed window average (registered)
//   fill   out  LOG2_N+1 number of valid samples in the window, 0..N
//   full   out  1        fill == N
//   valid  out  1        one-cycle pulse: sample accepted, window full after it
//
// Build option:
//   AVG_ROUND_EN  defined   -> avg = (sum + N/2) >>> LOG2_N (round half up)
//                 undefined -> avg = sum >>> LOG2_N (floor)
module win_avg #(
  parameter int DATA_W = 32,
  parameter int LOG2_N = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  input  logic [DATA_W-1:0]          x,
  output logic [DATA_W+LOG2_N-1:0]   sum,
  output logic [DATA_W-1:0]          avg,
  output logic [LOG2_N:0]            fill,
  output logic                       full,
  output logic                       valid
);

  localparam int ACC_W = DATA_W + LOG2_N;
  localparam int N     = 1 << LOG2_N;
  localparam logic [LOG2_N:0] FILL_MAX = (LOG2_N+1)'(1) << LOG2_N;

  // Sample history. Never reset: fill/full mask stale entries.
  logic [DATA_W-1:0] mem [N];

  logic [LOG2_N-1:0]       wptr;
  logic signed [ACC_W-1:0] sum_q;
  logic [DATA_W-1:0]       avg_q;
  logic [LOG2_N:0]         fill_q;
  logic                    full_q;
  logic                    valid_q;

  logic                    flush;
  logic                    accept;
  logic [DATA_W-1:0]       old;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] old_ext;
  logic signed [ACC_W-1:0] sum_nxt;
  logic [LOG2_N:0]         fill_nxt;
  logic [DATA_W-1:0]       avg_nxt;

  assign flush  = rst | clr;
  assign accept = en & ~flush;

  // Asynchronous read of the slot about to be overwritten; it only leaves
  // the sum once the window is full, before that it was never added.
  assign old     = full_q ? mem[wptr] : '0;
  assign x_ext   = {{LOG2_N{x[DATA_W-1]}}, x};
  assign old_ext = {{LOG2_N{old[DATA_W-1]}}, old};
  assign sum_nxt = sum_q + x_ext - old_ext;

  assign fill_nxt = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;

`ifdef AVG_ROUND_EN
  // One extra bit so adding N/2 to the largest sum cannot wrap.
  localparam logic [ACC_W:0] HALF = (ACC_W+1)'(1) << (LOG2_N-1);
  logic [ACC_W:0] rnd;
  logic           unused_rnd;

  assign rnd        = {sum_nxt[ACC_W-1], sum_nxt} + HALF;
  // >>> LOG2_N then truncate to DATA_W is exactly this bit slice.
  assign avg_nxt    = rnd[ACC_W-1:LOG2_N];
  assign unused_rnd = ^{rnd[ACC_W], rnd[LOG2_N-1:0]};
`else
  // Arithmetic shift by LOG2_N truncated to DATA_W == upper slice of the sum.
  assign avg_nxt = sum_nxt[ACC_W-1:LOG2_N];
`endif

  always_ff @(posedge clk) begin
    if (accept) mem[wptr] <= x;
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wptr    <= '0;
      sum_q   <= '0;
      avg_q   <= '0;
      fill_q  <= '0;
      full_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (accept) begin
      wptr    <= wptr + 1'b1;
      sum_q   <= sum_nxt;
      avg_q   <= avg_nxt;
      fill_q  <= fill_nxt;
      full_q  <= (fill_nxt == FILL_MAX);
      valid_q <= (fill_nxt == FILL_MAX);
    end else begin
      valid_q <= 1'b0;
    end
  end

  assign sum   = sum_q;
  assign avg   = avg_q;
  assign fill  = fill_q;
  assign full  = full_q;
  assign valid = valid_q;

endmodule

// File: doc/win_avg.md
Name: win_avg

Overview:
- Parametrised sliding-window averager; next generation of the team's single-accumulator `circuit` block.
- Accepts one signed sample per `en` strobe and stores the last 2^LOG2_N samples in a circular buffer.
- Keeps a running window sum and a registered average. Division is a shift, so no divider is needed.
- Sits between a sample producer and any consumer that needs a smoothed value, e.g. a sensor front-end or stats readout.

Parameters:
- DATA_W, 32, sample width in bits; signed two's complement.
- LOG2_N, 7, log2 of the window length; N = 2^LOG2_N samples (default 128). LOG2_N >= 1.
- ACC_W, DATA_W+LOG2_N, derived localparam; accumulator width. Not overridable.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- clr  in  1  synchronous window clear; same effect as rst on state and outputs.
- en  in  1  sample strobe; x is accepted on any rising edge where en=1.
- x  in  DATA_W  signed input sample.
- sum  out  ACC_W  signed sum of the samples currently in the window.
- avg  out  DATA_W  signed window average, registered.
- fill  out  LOG2_N+1  number of valid samples in the window, 0..N.
- full  out  1  high when fill==N.
- valid  out  1  one-cycle pulse: sample accepted with the window full after acceptance.

Behaviour:
- Reset (rst=1 at an edge):
  - sum, avg, fill, full, valid, write pointer all go to 0.
  - Buffer contents are not cleared; fill masks them.
  - Reset mid-stream discards all history.
- clr behaves exactly like rst. clr and en in the same cycle: clr wins and the sample is dropped.
- Accept (en=1, no rst/clr), all updates at that edge, latency 1 cycle:
  - `old` = buf[wptr] when full=1, else 0.
  - buf[wptr] <= x. wptr <= wptr+1, wrapping N-1 -> 0 (natural LOG2_N-bit wrap).
  - sum <= sum + sext(x) - sext(old), computed in ACC_W bits. ACC_W guarantees no overflow.
  - fill <= fill+1, saturating at N. full follows fill.
  - avg <= sum_next >>> LOG2_N (arithmetic shift, floor toward -inf), truncated to DATA_W.
    - This value is always representable.
    - avg is updated even while the window is not full: it equals partial sum / N.
  - valid <= 1 if fill_next==N, else 0. The N-th sample after reset pulses valid, as does every sample after it.
- Idle (en=0): all state holds; valid <= 0.
- Back-to-back en every cycle is supported with no bubbles. Read-before-write on buf[wptr] in the same cycle must return the old value.
- Buffer is a plain register array or inferred single-port RAM with asynchronous read; no handshake back-pressure.
- Simultaneous rst and clr: reset result.

Optional Feature:
- Macro AVG_ROUND_EN.
- Defined: avg <= (sum_next + 2^(LOG2_N-1)) >>> LOG2_N, i.e. round half toward +inf. The rounding add uses ACC_W+1 bits to avoid overflow.
- Undefined: plain arithmetic shift (floor). sum, fill, full and valid are identical in both builds.

Test Plan (bench uses DATA_W=8, LOG2_N=2, so N=4; run in both builds):
- Hold rst=1 for 2 edges, then release -> sum=0, avg=0, fill=0, full=0, valid=0; en=0 for 5 cycles leaves all unchanged.
- Samples 1,2,3,4 on consecutive cycles:
  - fill 1,2,3,4; sum 1,3,6,10.
  - After the 4th sample: full=1, valid pulses once, avg=2 (floor) / 3 (AVG_ROUND_EN).
- Continue with sample 8 (1 is evicted) -> sum=17, avg=4 in both builds, valid pulses. A 5-cycle gap with en=0 keeps sum=17 and valid=0.
- clr, then samples -1,-2,-3,-4 -> sum=-10, avg=-3 (floor) / -2 (round), full=1.
- clr and en=1 with x=50 in the same cycle -> fill=0, sum=0, sample dropped. The next single sample 5 gives fill=1, sum=5, avg=1, valid=0.
- 100 samples, x=$random%20, en pulsed every other cycle:
  - Every cycle, sum, avg and fill must match a reference model of the last 4 accepted samples.
  - One rst asserted mid-run: the model resets too.
